// File: rtl/rv32i_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package rv32i_mem_arbiter_pkg;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned BE_W                = XLEN / 8;
  localparam int unsigned ARB_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  // Request payload latched at acceptance and replayed onto the memory port.
  typedef struct packed {
    logic            we;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// Fetch, data and memory-port signals of the arbiter; slave = arbiter side.
interface rv32i_mem_arbiter_if import rv32i_mem_arbiter_pkg::*; ();

  logic            ireq_valid_i;
  logic [XLEN-1:0] ireq_addr_i;
  logic            ireq_ready_o;
  logic            iflush_i;
  logic            irsp_valid_o;
  logic [XLEN-1:0] irsp_rdata_o;

  logic            dreq_valid_i;
  logic            dreq_we_i;
  logic [BE_W-1:0] dreq_be_i;
  logic [XLEN-1:0] dreq_addr_i;
  logic [XLEN-1:0] dreq_wdata_i;
  logic            dreq_ready_o;
  logic            drsp_valid_o;
  logic [XLEN-1:0] drsp_rdata_o;

  logic            rsp_err_o;

  logic            mem_req_o;
  logic            mem_we_o;
  logic [BE_W-1:0] mem_be_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  logic            busy_o;

  modport slave (
    input  ireq_valid_i, ireq_addr_i, iflush_i,
    input  dreq_valid_i, dreq_we_i, dreq_be_i, dreq_addr_i, dreq_wdata_i,
    input  mem_rvalid_i, mem_rdata_i,
    output ireq_ready_o, irsp_valid_o, irsp_rdata_o,
    output dreq_ready_o, drsp_valid_o, drsp_rdata_o,
    output rsp_err_o, busy_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output ireq_valid_i, ireq_addr_i, iflush_i,
    output dreq_valid_i, dreq_we_i, dreq_be_i, dreq_addr_i, dreq_wdata_i,
    output mem_rvalid_i, mem_rdata_i,
    input  ireq_ready_o, irsp_valid_o, irsp_rdata_o,
    input  dreq_ready_o, drsp_valid_o, drsp_rdata_o,
    input  rsp_err_o, busy_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/rv32i_arb_watchdog.sv
// Saturating wait-state counter; flags expiry once TIMEOUT cycles have elapsed.
module rv32i_arb_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != {CW{1'b1}})) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // TIMEOUT of zero disables expiry entirely.
  assign expired_o = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Single-port memory arbiter: data requests beat fetch, one transaction at a time,
// with a watchdog and suppression of fetch responses killed by a taken branch.
module rv32i_mem_arbiter
  import rv32i_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  rv32i_mem_arbiter_if.slave   bus
);

  arb_state_t      state_q, state_d;
  arb_owner_t      owner_q;
  arb_req_t        req_q;
  arb_req_t        dreq_pl, ireq_pl;
  logic            drop_q, err_q;
  logic [XLEN-1:0] irdata_q, drdata_q;
  logic            wd_expired;
  logic            flush_hit;

  logic ireq_ready_c, dreq_ready_c, mem_req_c;
  logic irsp_valid_c, drsp_valid_c, rsp_err_c, busy_c;

  assign dreq_pl = '{we: bus.dreq_we_i, be: bus.dreq_be_i,
                     addr: bus.dreq_addr_i, wdata: bus.dreq_wdata_i};
  assign ireq_pl = '{we: 1'b0, be: {BE_W{1'b1}},
                     addr: bus.ireq_addr_i, wdata: XLEN'(0)};

  rv32i_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q == ARB_ISSUE),
    .en_i      ((state_q == ARB_WAIT) && !bus.mem_rvalid_i),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (bus.dreq_valid_i || bus.ireq_valid_i) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT:  if (bus.mem_rvalid_i || wd_expired) state_d = ARB_RESP;
      ARB_RESP:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // A flush in the response cycle itself must still kill that response.
  always_comb begin
    ireq_ready_c = 1'b0;
    dreq_ready_c = 1'b0;
    mem_req_c    = 1'b0;
    irsp_valid_c = 1'b0;
    drsp_valid_c = 1'b0;
    busy_c       = (state_q != ARB_IDLE);
    unique case (state_q)
      ARB_IDLE: begin
        dreq_ready_c = bus.dreq_valid_i && !rst_i;
        ireq_ready_c = !bus.dreq_valid_i && bus.ireq_valid_i && !rst_i;
      end
      ARB_ISSUE: mem_req_c = 1'b1;
      ARB_RESP: begin
        if (owner_q == OWN_D) drsp_valid_c = 1'b1;
        else                  irsp_valid_c = !(drop_q || bus.iflush_i);
      end
      default: ;
    endcase
    rsp_err_c = err_q && (irsp_valid_c || drsp_valid_c);
  end

  assign flush_hit = bus.iflush_i &&
                     (ireq_ready_c || ((state_q != ARB_IDLE) && (owner_q == OWN_I)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q  <= OWN_I;
      req_q    <= '0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      if (dreq_ready_c) begin
        owner_q <= OWN_D;
        req_q   <= dreq_pl;
      end else if (ireq_ready_c) begin
        owner_q <= OWN_I;
        req_q   <= ireq_pl;
      end

      if (state_q == ARB_RESP) drop_q <= 1'b0;
      else if (flush_hit)      drop_q <= 1'b1;

      // Completion wins over a same-cycle watchdog expiry.
      if (state_q == ARB_WAIT) begin
        if (bus.mem_rvalid_i) begin
          err_q <= 1'b0;
          if (owner_q == OWN_D) drdata_q <= bus.mem_rdata_i;
          else                  irdata_q <= bus.mem_rdata_i;
        end else if (wd_expired) begin
          err_q <= 1'b1;
          if (owner_q == OWN_D) drdata_q <= '0;
          else                  irdata_q <= '0;
        end
      end
    end
  end

  assign bus.ireq_ready_o = ireq_ready_c;
  assign bus.dreq_ready_o = dreq_ready_c;
  assign bus.mem_req_o    = mem_req_c;
  assign bus.irsp_valid_o = irsp_valid_c;
  assign bus.drsp_valid_o = drsp_valid_c;
  assign bus.rsp_err_o    = rsp_err_c;
  assign bus.busy_o       = busy_c;
  assign bus.irsp_rdata_o = irdata_q;
  assign bus.drsp_rdata_o = drdata_q;
  assign bus.mem_we_o     = req_q.we;
  assign bus.mem_be_o     = req_q.be;
  assign bus.mem_addr_o   = req_q.addr;
  assign bus.mem_wdata_o  = req_q.wdata;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Scoreboard bench for rv32i_mem_arbiter with a wait-state-programmable memory model.
module tb_rv32i_mem_arbiter;
  import rv32i_mem_arbiter_pkg::*;

  typedef struct {
    bit          is_d;
    bit          chk_rdata;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_mem_arbiter_if bus ();
  rv32i_mem_arbiter #(.TIMEOUT(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model
  logic [31:0] tb_mem [0:255];
  int          ws         = 0;
  bit          mem_silent = 1'b0;
  logic        resp_rvalid = 1'b0;
  logic        stray_rvalid = 1'b0;
  logic [31:0] resp_rdata = 32'h0;
  int          req_cnt = 0;
  assign bus.mem_rvalid_i = resp_rvalid | stray_rvalid;
  assign bus.mem_rdata_i  = resp_rdata;

  always begin : responder
    logic [31:0] rd;
    @(negedge clk);
    if (bus.mem_req_o === 1'b1) begin
      req_cnt = req_cnt + 1;
      if (!mem_silent) begin
        rd = bus.mem_we_o ? 32'h0 : tb_mem[bus.mem_addr_o[9:2]];
        @(negedge clk);
        repeat (ws) @(negedge clk);
        resp_rvalid = 1'b1;
        resp_rdata  = rd;
        @(negedge clk);
        resp_rvalid = 1'b0;
        resp_rdata  = 32'hBAD0_BAD0;
      end
    end
  end

  // Response monitor
  int          rsp_count = 0;
  bit          obs_d    [0:63];
  bit          obs_both [0:63];
  logic [31:0] obs_rdata[0:63];
  logic        obs_err  [0:63];
  int          obs_cyc  [0:63];
  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_count < 64 &&
        (bus.irsp_valid_o === 1'b1 || bus.drsp_valid_o === 1'b1)) begin
      obs_d[rsp_count]     = (bus.drsp_valid_o === 1'b1);
      obs_both[rsp_count]  = (bus.drsp_valid_o === 1'b1) && (bus.irsp_valid_o === 1'b1);
      obs_rdata[rsp_count] = (bus.drsp_valid_o === 1'b1) ? bus.drsp_rdata_o : bus.irsp_rdata_o;
      obs_err[rsp_count]   = bus.rsp_err_o;
      obs_cyc[rsp_count]   = cyc;
      rsp_count = rsp_count + 1;
    end
  end

  exp_t sb[$];
  int   rd_idx = 0;

  initial begin
    #400000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.ireq_valid_i = 1'b0; bus.ireq_addr_i = 32'h0; bus.iflush_i = 1'b0;
    bus.dreq_valid_i = 1'b0; bus.dreq_we_i = 1'b0; bus.dreq_be_i = 4'h0;
    bus.dreq_addr_i  = 32'h0; bus.dreq_wdata_i = 32'h0;
  endtask

  task automatic push_exp(input bit is_d, input bit chk, input logic [31:0] rdata, input bit err);
    exp_t e;
    e.is_d = is_d; e.chk_rdata = chk; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_rsp(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rsp_count >= target) break;
      step();
    end
    ok = (rsp_count >= target);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (rd_idx < rsp_count) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got is_d=%0b rdata=%08h err=%0b at cyc %0d, expected no response",
                 obs_d[rd_idx], obs_rdata[rd_idx], obs_err[rd_idx], obs_cyc[rd_idx]);
      end else begin
        e = sb.pop_front();
        if (obs_both[rd_idx] || obs_d[rd_idx] !== e.is_d || obs_err[rd_idx] !== e.err ||
            (e.chk_rdata && obs_rdata[rd_idx] !== e.rdata)) begin
          n_fail++;
          $display("FAIL sb_rsp: got is_d=%0b both=%0b rdata=%08h err=%0b, expected is_d=%0b rdata=%08h err=%0b",
                   obs_d[rd_idx], obs_both[rd_idx], obs_rdata[rd_idx], obs_err[rd_idx],
                   e.is_d, e.rdata, e.err);
        end
      end
      rd_idx++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ireq_valid_i = 1'b1; bus.dreq_valid_i = 1'b1; bus.ireq_addr_i = 32'h44;
    step();
    n_tests++;
    if ({bus.ireq_ready_o, bus.dreq_ready_o, bus.busy_o, bus.mem_req_o,
         bus.irsp_valid_o, bus.drsp_valid_o, bus.rsp_err_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, expected 0000000",
               {bus.ireq_ready_o, bus.dreq_ready_o, bus.busy_o, bus.mem_req_o,
                bus.irsp_valid_o, bus.drsp_valid_o, bus.rsp_err_o});
    end
    n_tests++;
    if (bus.irsp_rdata_o !== 32'h0 || bus.drsp_rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got i=%08h d=%08h, expected 0", bus.irsp_rdata_o, bus.drsp_rdata_o);
    end
    n_tests++;
    if (bus.mem_addr_o !== 32'h0 || bus.mem_wdata_o !== 32'h0 || bus.mem_be_o !== 4'h0 ||
        bus.mem_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mem: got addr=%08h wdata=%08h be=%h we=%b, expected 0",
               bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o, bus.mem_we_o);
    end
    idle_inputs();
    rst = 1'b0;
    step();
    n_tests++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_busy: got %b, expected 0", bus.busy_o);
    end
  endtask

  task automatic test_fetch_only();
    int t; bit ok;
    ws = 0;
    tb_mem[8'h40] = 32'h0000_0013;
    step();
    bus.ireq_valid_i = 1'b1; bus.ireq_addr_i = 32'h100;
    #1;
    t = cyc;
    n_tests++;
    if (bus.ireq_ready_o !== 1'b1 || bus.dreq_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_accept: got iready=%b dready=%b, expected 1 0", bus.ireq_ready_o, bus.dreq_ready_o);
    end
    push_exp(1'b0, 1'b1, 32'h0000_0013, 1'b0);
    step();
    bus.ireq_valid_i = 1'b0;
    n_tests++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h100 || bus.mem_we_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_issue: got req=%b addr=%08h we=%b busy=%b, expected 1 00000100 0 1",
               bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o, bus.busy_o);
    end
    step();
    n_tests++;
    if (bus.mem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_req_pulse: got mem_req=%b at T+2, expected 0", bus.mem_req_o);
    end
    wait_rsp(rsp_count + 1, 10, ok);
    n_tests++;
    if (!ok || obs_cyc[rsp_count-1] != t + 3) begin
      n_fail++;
      $display("FAIL fetch_latency: got ok=%0b cyc=%0d, expected response at %0d", ok, obs_cyc[rsp_count-1], t + 3);
    end
    step();
    n_tests++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_busy_T4: got %b, expected 0", bus.busy_o);
    end
    sb_drain();
  endtask

  task automatic test_simultaneous();
    int t; int acc; int start; bit ok;
    ws = 0;
    tb_mem[8'h41] = 32'h0000_0093;
    start = rsp_count;
    step();
    bus.dreq_valid_i = 1'b1; bus.dreq_we_i = 1'b1; bus.dreq_be_i = 4'hF;
    bus.dreq_addr_i = 32'h200; bus.dreq_wdata_i = 32'hDEAD_BEEF;
    bus.ireq_valid_i = 1'b1; bus.ireq_addr_i = 32'h104;
    #1;
    t = cyc;
    n_tests++;
    if (bus.dreq_ready_o !== 1'b1 || bus.ireq_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_priority: got dready=%b iready=%b, expected 1 0", bus.dreq_ready_o, bus.ireq_ready_o);
    end
    push_exp(1'b1, 1'b0, 32'h0, 1'b0);
    push_exp(1'b0, 1'b1, 32'h0000_0093, 1'b0);
    step();
    bus.dreq_valid_i = 1'b0; bus.dreq_we_i = 1'b0;
    n_tests++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 32'h200 ||
        bus.mem_wdata_o !== 32'hDEAD_BEEF || bus.mem_be_o !== 4'hF) begin
      n_fail++;
      $display("FAIL simul_store_issue: got req=%b we=%b addr=%08h wdata=%08h be=%h, expected 1 1 00000200 deadbeef f",
               bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o);
    end
    acc = -1;
    for (int i = 0; i < 12; i++) begin
      if (bus.ireq_ready_o === 1'b1) begin acc = cyc; break; end
      step();
    end
    n_tests++;
    if (acc != t + 4) begin
      n_fail++;
      $display("FAIL simul_fetch_accept: got cyc %0d, expected %0d", acc, t + 4);
    end
    step();
    bus.ireq_valid_i = 1'b0;
    wait_rsp(start + 2, 12, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL simul_rsp_count: got %0d responses, expected %0d", rsp_count - start, 2);
    end
    sb_drain();
  endtask

  task automatic test_flush();
    int t; int start; int rq; bit idle;
    ws = 2;
    tb_mem[8'h42] = 32'h1234_5678;
    tb_mem[8'h43] = 32'h00C0_0093;
    start = rsp_count; rq = req_cnt;
    step();
    bus.ireq_valid_i = 1'b1; bus.ireq_addr_i = 32'h108;
    step();
    bus.ireq_valid_i = 1'b0;
    step();
    bus.iflush_i = 1'b1;
    step();
    bus.iflush_i = 1'b0;
    idle = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.busy_o === 1'b0) begin idle = 1'b1; break; end
      step();
    end
    n_tests++;
    if (!idle || rsp_count != start || req_cnt != rq + 1) begin
      n_fail++;
      $display("FAIL flush_drop: got idle=%0b rsps=%0d memreqs=%0d, expected 1 0 1",
               idle, rsp_count - start, req_cnt - rq);
    end
    ws = 0;
    step();
    bus.ireq_valid_i = 1'b1; bus.ireq_addr_i = 32'h10C;
    #1;
    t = cyc;
    push_exp(1'b0, 1'b1, 32'h00C0_0093, 1'b0);
    step();
    bus.ireq_valid_i = 1'b0;
    wait_rsp(start + 1, 10, idle);
    n_tests++;
    if (!idle || obs_cyc[rsp_count-1] != t + 3) begin
      n_fail++;
      $display("FAIL flush_next_fetch: got ok=%0b cyc=%0d, expected response at %0d", idle, obs_cyc[rsp_count-1], t + 3);
    end
    sb_drain();
  endtask

  task automatic test_back_to_back();
    int acc[4]; int k; int start; bit ok;
    ws = 2;
    for (int i = 0; i < 4; i++) tb_mem[8'h00 + 8'(i)] = 32'hA5A5_0000 + 32'(i);
    start = rsp_count;
    k = 0;
    step();
    bus.dreq_valid_i = 1'b1; bus.dreq_we_i = 1'b0; bus.dreq_be_i = 4'hF; bus.dreq_addr_i = 32'h0;
    for (int s = 0; s < 60 && k < 4; s++) begin
      #1;
      if (bus.dreq_ready_o === 1'b1) begin
        acc[k] = cyc;
        push_exp(1'b1, 1'b1, 32'hA5A5_0000 + 32'(k), 1'b0);
        k++;
        step();
        if (k < 4) bus.dreq_addr_i = 32'(k * 4);
        else       bus.dreq_valid_i = 1'b0;
      end else begin
        step();
      end
    end
    bus.dreq_valid_i = 1'b0;
    n_tests++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL b2b_accepts: got %0d, expected 4", k);
    end
    for (int i = 1; i < 4; i++) begin
      n_tests++;
      if (k == 4 && acc[i] - acc[i-1] != 6) begin
        n_fail++;
        $display("FAIL b2b_spacing%0d: got %0d cycles, expected 6", i, acc[i] - acc[i-1]);
      end
    end
    wait_rsp(start + 4, 20, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_rsp_count: got %0d, expected 4", rsp_count - start);
    end
    sb_drain();
  endtask

  task automatic test_timeout();
    int t; int start; bit ok;
    mem_silent = 1'b1;
    start = rsp_count;
    step();
    bus.dreq_valid_i = 1'b1; bus.dreq_we_i = 1'b0; bus.dreq_be_i = 4'hF; bus.dreq_addr_i = 32'h300;
    #1;
    t = cyc;
    push_exp(1'b1, 1'b1, 32'h0, 1'b1);
    step();
    bus.dreq_valid_i = 1'b0;
    wait_rsp(start + 1, 20, ok);
    n_tests++;
    if (!ok || obs_cyc[rsp_count-1] != t + 7) begin
      n_fail++;
      $display("FAIL timeout_latency: got ok=%0b cyc=%0d, expected response at %0d", ok, obs_cyc[rsp_count-1], t + 7);
    end
    sb_drain();
    step();
    stray_rvalid = 1'b1;
    step();
    stray_rvalid = 1'b0;
    step();
    step();
    n_tests++;
    if (rsp_count != start + 1 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_stray: got rsps=%0d busy=%b, expected 1 0", rsp_count - start, bus.busy_o);
    end
    mem_silent = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t; int start; bit ok;
    ws = 3;
    tb_mem[8'h10] = 32'h0BAD_F00D;
    tb_mem[8'h11] = 32'h1357_9BDF;
    start = rsp_count;
    step();
    bus.dreq_valid_i = 1'b1; bus.dreq_we_i = 1'b0; bus.dreq_be_i = 4'hF; bus.dreq_addr_i = 32'h40;
    step();
    bus.dreq_valid_i = 1'b0;
    step();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.busy_o, bus.mem_req_o, bus.drsp_valid_o, bus.irsp_valid_o, bus.rsp_err_o, bus.mem_we_o} !== 6'b0 ||
        bus.drsp_rdata_o !== 32'h0 || bus.irsp_rdata_o !== 32'h0 || bus.mem_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got busy=%b req=%b drdata=%08h irdata=%08h addr=%08h, expected all 0",
               bus.busy_o, bus.mem_req_o, bus.drsp_rdata_o, bus.irsp_rdata_o, bus.mem_addr_o);
    end
    step();
    rst = 1'b0;
    repeat (8) step();
    n_tests++;
    if (rsp_count != start || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_late_rvalid: got rsps=%0d busy=%b, expected 0 0", rsp_count - start, bus.busy_o);
    end
    ws = 0;
    bus.dreq_valid_i = 1'b1; bus.dreq_addr_i = 32'h44;
    #1;
    t = cyc;
    push_exp(1'b1, 1'b1, 32'h1357_9BDF, 1'b0);
    step();
    bus.dreq_valid_i = 1'b0;
    wait_rsp(start + 1, 10, ok);
    n_tests++;
    if (!ok || obs_cyc[rsp_count-1] != t + 3) begin
      n_fail++;
      $display("FAIL reset_mid_next: got ok=%0b cyc=%0d, expected response at %0d", ok, obs_cyc[rsp_count-1], t + 3);
    end
    sb_drain();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_flush();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (3) step();
    sb_drain();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
